// File: rtl/scl_v_fltr_ctrl_if.sv
// Pixel handshake, filter strobe and tagged-output bundle for the vertical filter sequencer.
// master = controller side, slave = pixel source / filter / consumer side.
interface scl_v_fltr_ctrl_if;
  logic       start;
  logic       pix_valid;
  logic       pix_rdy;
  logic       nd;
  logic       flush;
  logic       out_vld;
  logic [9:0] out_line;
  logic [9:0] out_col;
  logic       busy;
  logic       frame_done;

  modport master (
    input  start, pix_valid,
    output pix_rdy, nd, flush, out_vld, out_line, out_col, busy, frame_done
  );

  modport slave (
    output start, pix_valid,
    input  pix_rdy, nd, flush, out_vld, out_line, out_col, busy, frame_done
  );
endinterface

// File: rtl/scl_v_fltr_ctrl.sv
// Vertical scaling filter sequencer: issues the nd strobe, throttles upstream pixels,
// drains the line FIFOs with zeros and tags each valid filter output with its position.
module scl_v_fltr_ctrl #(
  parameter int LINE_LEN    = 496,
  parameter int FRAME_LINES = 480,
  parameter int FILL_LINES  = 4,
  parameter int DRAIN_LINES = 4,
  parameter int ND_GAP      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  scl_v_fltr_ctrl_if.master     ctrl,
  output logic [1:0]            o_dbg_state
);
  // Handshake: a pixel transfers on any cycle where pix_valid && pix_rdy; pix_rdy never
  // depends on pix_valid, and nd is exactly that transfer (RUN) or a self-issued strobe (DRAIN).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [9:0] LAST_COL      = 10'(LINE_LEN - 1);
  localparam logic [9:0] LAST_RUN_LINE = 10'(FRAME_LINES - 1);
  localparam logic [9:0] LAST_LINE     = 10'(FRAME_LINES + DRAIN_LINES - 1);
  localparam logic [9:0] VLD_LINE      = 10'(FILL_LINES + 1);
  localparam logic [3:0] GAP_LOAD      = 4'(ND_GAP - 1);

  state_t     r_state;
  state_t     w_next;
  logic [9:0] r_col;
  logic [9:0] r_line;
  logic [3:0] r_gap;
  logic       r_flush;
  logic       r_out_vld;
  logic [9:0] r_out_line;
  logic [9:0] r_out_col;
  logic       r_done;

  logic       w_gap_ok;
  logic       w_last_col;
  logic       w_rdy;
  logic       w_nd;
  logic       w_clear;
  logic       w_done;

  assign w_gap_ok   = (r_gap == 4'd0);
  assign w_last_col = (r_col == LAST_COL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_rdy   = 1'b0;
    w_nd    = 1'b0;
    w_clear = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ctrl.start) begin
          w_clear = 1'b1;
          w_next  = S_RUN;
        end
      end
      S_RUN: begin
        w_rdy = w_gap_ok;
        w_nd  = ctrl.pix_valid & w_gap_ok;
        if (w_nd && w_last_col && (r_line == LAST_RUN_LINE)) begin
          if (DRAIN_LINES == 0) begin
            w_next = S_IDLE;
            w_done = 1'b1;
          end else begin
            w_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_nd = w_gap_ok;
        if (w_nd && w_last_col && (r_line == LAST_LINE)) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Line wraps to 0 on the final strobe so the counter never exceeds its range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= 10'd0;
      r_line <= 10'd0;
      r_gap  <= 4'd0;
    end else if (w_clear) begin
      r_col  <= 10'd0;
      r_line <= 10'd0;
      r_gap  <= 4'd0;
    end else if (w_nd) begin
      r_gap <= GAP_LOAD;
      if (w_last_col) begin
        r_col  <= 10'd0;
        r_line <= (r_line == LAST_LINE) ? 10'd0 : r_line + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end else if (!w_gap_ok) begin
      r_gap <= r_gap - 4'd1;
    end
  end

  // The filter output register lags its input by one strobe, hence the extra line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush    <= 1'b0;
      r_done     <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_line <= 10'd0;
      r_out_col  <= 10'd0;
    end else begin
      r_flush   <= (w_next == S_DRAIN);
      r_done    <= w_done;
      r_out_vld <= w_nd && (r_line >= VLD_LINE);
      if (w_nd && (r_line >= VLD_LINE)) begin
        r_out_line <= r_line - VLD_LINE;
        r_out_col  <= r_col;
      end
    end
  end

  assign ctrl.pix_rdy    = w_rdy;
  assign ctrl.nd         = w_nd;
  assign ctrl.flush      = r_flush;
  assign ctrl.out_vld    = r_out_vld;
  assign ctrl.out_line   = r_out_line;
  assign ctrl.out_col    = r_out_col;
  assign ctrl.busy       = (r_state != S_IDLE);
  assign ctrl.frame_done = r_done;
  assign o_dbg_state     = r_state;
endmodule

// File: doc/scl_v_fltr_ctrl.md
# scl_v_fltr_ctrl

Sequencer for the vertical scaling filter. Owns the `nd` strobe that advances the filter's line FIFOs and output registers, and throttles upstream pixels through a valid/ready handshake with a programmable minimum strobe spacing. Drains the line FIFOs with zero pixels after the last input line. Tags each filtered output pixel with a valid pulse and its line/column position. Sits between the pixel source and the vertical filter; its outputs feed the filter's `nd`, a zero-mux on the filter's `d_in`, and the downstream consumer.

## Interface
- LINE_LEN, 496: pixels per line; must match the filter FIFO depth; range 2..1023
- FRAME_LINES, 480: input lines per frame; range 1..1023
- FILL_LINES, 4: filter line latency; outputs before this line index are not flagged valid
- DRAIN_LINES, 4: zero lines pushed after the last input line; 0 allowed
- ND_GAP, 1: minimum clk cycles between `nd` pulses; 1 means back-to-back; range 1..15

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start request
- pix_valid  in  1  upstream pixel available
- pix_rdy  out  1  controller accepts the pixel this cycle
- nd  out  1  filter advance strobe (combinational)
- flush  out  1  selects zero onto filter `d_in` during drain (registered)
- out_vld  out  1  filter output registers hold a valid pixel (registered)
- out_line  out  10  line index of the `out_vld` pixel
- out_col  out  10  column index of the `out_vld` pixel
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse after the last drain strobe

## Operation
- Counters:
  - `col` runs 0..LINE_LEN-1.
  - `line` runs 0..FRAME_LINES+DRAIN_LINES-1.
  - `gap` runs 0..ND_GAP-1.
  - Every counter is 10 bits or narrower, with no arithmetic overflow.
- On each `nd`:
  - `col` increments; at LINE_LEN-1 it wraps to 0 and `line` increments.
  - `gap` loads ND_GAP-1, then decrements to 0 on later cycles.
- `gap` == 0 is the strobe-permitted condition.
- States:
  - IDLE:
    - `pix_rdy`=0, `nd`=0.
    - `start`=1 clears `col`, `line` and `gap`, then goes to RUN.
  - RUN:
    - `pix_rdy` = (`gap`==0).
    - `nd` = `pix_valid` & `pix_rdy`.
    - On the `nd` for `col`=LINE_LEN-1, `line`=FRAME_LINES-1: go to DRAIN, or to IDLE with `frame_done` if DRAIN_LINES=0.
  - DRAIN:
    - `pix_rdy`=0, `flush`=1.
    - `nd` = (`gap`==0), self-issued.
    - On the `nd` for `col`=LINE_LEN-1, `line`=FRAME_LINES+DRAIN_LINES-1: go to IDLE and pulse `frame_done` the next cycle.
- `flush` is registered and is high exactly while the state is DRAIN.
- `out_vld` fires one cycle after any `nd` (RUN or DRAIN) whose pre-increment `line` >= FILL_LINES+1. The filter's output register lags its input by one strobe.
- When `out_vld` fires:
  - `out_line` = that strobe's `line` - FILL_LINES - 1.
  - `out_col` = that strobe's `col`.
  - Both hold their value between pulses.
- Boundary rules:
  - `start` while `busy` is ignored.
  - `start` in the same cycle as the final drain strobe is ignored; the controller still goes to IDLE.
  - `pix_valid` while IDLE or DRAIN is never accepted; upstream holds its pixel.
  - `pix_valid` dropping mid-line stalls the counters without error.
  - ND_GAP=1 permits `nd` every cycle.

## Timing
- Reset:
  - State goes to IDLE.
  - All counters go to 0.
  - `pix_rdy`, `nd`, `flush`, `out_vld`, `busy`, `frame_done`, `out_line` and `out_col` all go to 0.
- Reset is asynchronous and can interrupt a frame at any cycle. No `frame_done` is issued; the next frame starts only on a fresh `start`.
- `start` at edge N: `busy`=1 and `pix_rdy`=1 in cycle N+1.
- `pix_rdy` depends only on state and `gap`, never on `pix_valid`.
- `nd` is combinational from `pix_valid` in RUN, so the filter samples on the same edge the handshake completes.
- `out_vld` is asserted in the cycle after the qualifying `nd` edge.
- `busy` falls the cycle after the final `nd`, coincident with `frame_done`=1.
- Total strobes per frame = LINE_LEN × (FRAME_LINES+DRAIN_LINES).

## Test plan
All scenarios use LINE_LEN=4, FRAME_LINES=3, DRAIN_LINES=2, FILL_LINES=1, ND_GAP=1 unless noted.
- Reset then idle: hold `pix_valid`=1 with no `start` -> `pix_rdy`=0, `nd`=0, all outputs 0.
- Full frame with `pix_valid` held high after `start`:
  - 12 RUN strobes, then 8 DRAIN strobes with `flush`=1.
  - 12 `out_vld` pulses, the first one cycle after the strobe at `line`=2, `col`=0.
  - Last `out_vld` carries `out_line`=2, `out_col`=3.
  - `frame_done` one cycle after the 20th strobe.
- Throttle with ND_GAP=3: `nd` pulses exactly 3 cycles apart in both RUN and DRAIN; `pix_rdy` low for 2 cycles after each accept.
- Upstream stalls: `pix_valid` toggles pseudo-randomly -> strobe count is still 20, `col`/`line` never skip, `out_col` sequence is 0,1,2,3 repeating.
- `start` pulsed during RUN and on the final drain cycle -> ignored; controller returns to IDLE once, one `frame_done`.
- Assert `rst` after the 7th strobe -> immediate IDLE with all outputs 0; a new `start` replays the full-frame scenario exactly.
